// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, data width and the default baud divider.
// Used by both the transmitter and the matching receiver.
package uart_pkg;

  localparam int UART_DATA_W      = 8;
  localparam int UART_DEF_CLK_DIV = 434;  // 50 MHz / 115200

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte-push handshake and status bundle between the core and the buffered UART transmitter.
// master = byte source in the core, slave = uart_tx_fifo.
interface uart_tx_fifo_if
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
);

  logic [UART_DATA_W-1:0]      i_Data;
  logic                        i_Valid;
  logic                        o_Ready;
  logic                        o_TXD;
  logic                        o_Busy;
  logic                        o_Full;
  logic                        o_Empty;
  logic [$clog2(FIFO_DEPTH):0] o_Count;

  modport master (
    output i_Data, i_Valid,
    input  o_Ready, o_TXD, o_Busy, o_Full, o_Empty, o_Count
  );

  modport slave (
    input  i_Data, i_Valid,
    output o_Ready, o_TXD, o_Busy, o_Full, o_Empty, o_Count
  );

endinterface

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with exact occupancy count (0..DEPTH).
// Latency: written entry readable the cycle after the push; read data is show-ahead.
// Backpressure: writes refused while full (even with a same-cycle read), reads ignored while empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_acc;
  logic             rd_acc;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign wr_acc  = wr_en && !full;
  assign rd_acc  = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter; even parity bit added when UART_TX_PARITY_EN is defined.
// Latency: byte pushed into an empty FIFO with the FSM idle drives the start bit from the next edge.
// Backpressure: o_Ready = !o_Full; a byte presented while full is dropped, so hold i_Valid until ready.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = UART_DEF_CLK_DIV,
  parameter int FIFO_DEPTH = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic          i_CLK,
  input  logic          i_RST_N,
  uart_tx_fifo_if.slave tx
);

  localparam int STOP_LEN = STOP_BITS * CLK_DIV;
  localparam int BW       = $clog2(STOP_LEN);
  localparam int CW       = $clog2(FIFO_DEPTH) + 1;

  uart_state_t            state_q, state_d;
  logic [BW-1:0]          baud_q, baud_d;
  logic [2:0]             bit_q, bit_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic                   txd_q, txd_d;
  logic                   pop;
  logic                   bit_done;
  logic                   stop_done;

  logic [UART_DATA_W-1:0] fifo_rd_data;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [CW-1:0]          fifo_count;

`ifdef UART_TX_PARITY_EN
  logic par_q, par_d;
`endif

  sync_fifo #(
    .WIDTH (UART_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (i_CLK),
    .rst_n   (i_RST_N),
    .wr_en   (tx.i_Valid),
    .wr_data (tx.i_Data),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign bit_done  = (baud_q == BW'(CLK_DIV - 1));
  assign stop_done = (baud_q == BW'(STOP_LEN - 1));

  // txd_d is the line value for the state being entered, so the line is a clean register output.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + BW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        txd_d  = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rd_data;
          bit_d   = '0;
          txd_d   = 1'b0;
          state_d = ST_START;
`ifdef UART_TX_PARITY_EN
          par_d   = ^fifo_rd_data;
`endif
        end
      end
      ST_START: begin
        if (bit_done) begin
          baud_d  = '0;
          txd_d   = shift_q[0];
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          baud_d = '0;
          if (bit_q == 3'(UART_DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
            txd_d   = par_q;
            state_d = ST_PARITY;
`else
            txd_d   = 1'b1;
            state_d = ST_STOP;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[UART_DATA_W-1:1]};
            txd_d   = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_done) begin
          baud_d  = '0;
          txd_d   = 1'b1;
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (stop_done) begin
          baud_d  = '0;
          txd_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        baud_d  = '0;
        txd_d   = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx.o_TXD   = txd_q;
  assign tx.o_Busy  = (state_q != ST_IDLE) || !fifo_empty;
  assign tx.o_Full  = fifo_full;
  assign tx.o_Empty = fifo_empty;
  assign tx.o_Ready = !fifo_full;
  assign tx.o_Count = fifo_count;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: two instances (1 and 2 stop bits) share stimulus; each is compared every
// cycle against a frame-level queue model, plus literal checks on hand-derived waveforms.
module tb_uart_tx_fifo;

  localparam int DIV   = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int F0 = (10 + PAR) * DIV;  // frame cycles with one stop bit

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic [7:0] s_data  = '0;
  logic       s_valid = 1'b0;
  int         tests   = 0;
  int         fails   = 0;
  logic       tx_rec   [2][200];
  logic       busy_rec [200];

  always #5 clk = ~clk;

  // Line value of bit slot idx of a frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (PAR == 1 && idx == 9) return ^b;
    return 1'b1;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int SB   = g + 1;
    localparam int FLEN = (10 + PAR + SB - 1) * DIV;

    uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();
    assign bus.i_Data  = s_data;
    assign bus.i_Valid = s_valid;

    uart_tx_fifo #(
      .CLK_DIV    (DIV),
      .FIFO_DEPTH (DEPTH),
      .STOP_BITS  (SB)
    ) dut (
      .i_CLK   (clk),
      .i_RST_N (rst_n),
      .tx      (bus.slave)
    );

    logic [7:0] mq [$];
    logic       m_active = 1'b0;
    int         m_t      = 0;
    logic [7:0] m_cur    = '0;

    initial begin : model
      int            pre;
      int            cnt;
      logic [CW+4:0] act_v;
      logic [CW+4:0] exp_v;
      forever begin
        @(posedge clk);
        if (rst_n) begin
          pre = mq.size();
          if (m_active) begin
            m_t++;
            if (m_t == FLEN) m_active = 1'b0;
          end else if (pre > 0) begin
            m_cur    = mq.pop_front();
            m_active = 1'b1;
            m_t      = 0;
          end
          if (s_valid && pre < DEPTH) mq.push_back(s_data);
        end
        @(negedge clk);
        if (!rst_n) begin
          mq.delete();
          m_active = 1'b0;
          m_t      = 0;
        end
        cnt   = mq.size();
        exp_v = {(m_active ? frame_bit(m_cur, m_t / DIV) : 1'b1), (m_active || cnt > 0),
                 (cnt == DEPTH), (cnt == 0), (cnt != DEPTH), CW'(cnt)};
        act_v = {bus.o_TXD, bus.o_Busy, bus.o_Full, bus.o_Empty, bus.o_Ready, bus.o_Count};
        tests++;
        if (act_v !== exp_v) begin
          fails++;
          $display("FAIL model%0d @%0t txd,busy,full,empty,ready,count got %b required %b",
                   g, $time, act_v, exp_v);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Called on a negedge; returns on the negedge after the byte was accepted by instance 0.
  task automatic push(input logic [7:0] d, output int waited);
    s_data  = d;
    s_valid = 1'b1;
    waited  = 0;
    while (!g_dut[0].bus.o_Ready && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check("push_timeout", 64'(waited < 2000), 64'd1);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((g_dut[0].bus.o_Busy || g_dut[1].bus.o_Busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 64'(n < 2000), 64'd1);
    @(negedge clk);
  endtask

  // Sample starting at the current negedge (index = cycles since the pop edge).
  task automatic record(input int n);
    for (int i = 0; i < n; i++) begin
      tx_rec[0][i] = g_dut[0].bus.o_TXD;
      tx_rec[1][i] = g_dut[1].bus.o_TXD;
      busy_rec[i]  = g_dut[0].bus.o_Busy;
      @(negedge clk);
    end
  endtask

  // Cycles the line stays high from the first stop cycle to the next start bit.
  function automatic int high_run(input int inst);
    int base;
    base = DIV * (9 + PAR);
    for (int k = base; k < 200; k++) begin
      if (tx_rec[inst][k] == 1'b0) return k - base;
    end
    return -1;
  endfunction

  initial begin
    int          w;
    int          rate;
    logic        low;
    logic [63:0] v;

    @(negedge clk);
    check("rst_txd",   64'(g_dut[0].bus.o_TXD),   64'd1);
    check("rst_busy",  64'(g_dut[0].bus.o_Busy),  64'd0);
    check("rst_full",  64'(g_dut[0].bus.o_Full),  64'd0);
    check("rst_empty", 64'(g_dut[0].bus.o_Empty), 64'd1);
    check("rst_ready", 64'(g_dut[0].bus.o_Ready), 64'd1);
    check("rst_count", 64'(g_dut[0].bus.o_Count), 64'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Single byte 0x55: alternating bits, each DIV cycles.
    push(8'h55, w);
    check("55_queued", 64'(g_dut[0].bus.o_Count), 64'd1);
    @(negedge clk);
    record(F0 + 1);
    v = '0;
    for (int i = 0; i < 40; i++) v[i] = tx_rec[0][i];
    check("55_wave", v, (PAR == 1) ? 64'h00F0F0F0F0 : 64'hF0F0F0F0F0);
    check("55_busy_last", 64'(busy_rec[F0-1]), 64'd1);
    check("55_busy_fall", 64'(busy_rec[F0]),   64'd0);
    wait_idle();

    // Burst of six into a 4-deep FIFO: sixth stalls until frame 1 ends plus one idle cycle.
    for (int b = 1; b <= 5; b++) push(8'(b), w);
    check("burst_full",  64'(g_dut[0].bus.o_Full),  64'd1);
    check("burst_count", 64'(g_dut[0].bus.o_Count), 64'd4);
    check("burst_ready", 64'(g_dut[0].bus.o_Ready), 64'd0);
    push(8'h06, w);
    check("burst_stall", 64'(w), 64'(F0 + 1 - 3));
    wait_idle();

    // Push on the same edge the FSM pops the only entry.
    push(8'hC3, w);
    push(8'h3C, w);
    check("pushpop_count", 64'(g_dut[0].bus.o_Count), 64'd1);
    check("pushpop_txd",   64'(g_dut[0].bus.o_TXD),   64'd0);
    wait_idle();

    // Reset during data bit 3 of 0xA3 with another byte still queued.
    push(8'hA3, w);
    push(8'h5A, w);
    repeat (17) @(negedge clk);
    check("a3_bit3", 64'(g_dut[0].bus.o_TXD), 64'd0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_txd",   64'(g_dut[0].bus.o_TXD),   64'd1);
    check("arst_empty", 64'(g_dut[0].bus.o_Empty), 64'd1);
    check("arst_count", 64'(g_dut[0].bus.o_Count), 64'd0);
    check("arst_busy",  64'(g_dut[0].bus.o_Busy),  64'd0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    low = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (!g_dut[0].bus.o_TXD || !g_dut[1].bus.o_TXD || g_dut[0].bus.o_Busy) low = 1'b1;
      @(negedge clk);
    end
    check("no_residual", 64'(low), 64'd0);

    // Back-to-back frames: stop time plus one idle cycle before the next start bit.
    push(8'h11, w);
    push(8'h22, w);
    record(120);
    check("gap_sb1", 64'(high_run(0)), 64'(DIV + 1));
    check("gap_sb2", 64'(high_run(1)), 64'(2 * DIV + 1));
    wait_idle();

`ifdef UART_TX_PARITY_EN
    push(8'h07, w);
    @(negedge clk);
    record(46);
    check("par07_bit",  64'(tx_rec[0][36]), 64'd1);
    check("par07_len",  64'({busy_rec[43], busy_rec[44]}), 64'd2);
    wait_idle();
    push(8'h03, w);
    @(negedge clk);
    record(46);
    check("par03_bit",  64'(tx_rec[0][36]), 64'd0);
    wait_idle();
`endif

    // Random traffic at several offered loads; valid ignores ready so overflow drops occur.
    for (int ph = 0; ph < 6; ph++) begin
      rate = (ph % 3 == 0) ? 3 : ((ph % 3 == 1) ? 15 : 70);
      for (int c = 0; c < 600; c++) begin
        s_valid = ($urandom_range(0, 99) < rate);
        s_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    s_valid = 1'b0;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
